// File: rtl/cube_pkg.sv
// Shared constants, encodings and LCG helpers for the 2x2 cube move scheduler.
package cube_pkg;

  localparam int STICKER_W  = 3;
  localparam int N_STICKERS = 24;
  localparam int CUBE_W     = STICKER_W * N_STICKERS;

  localparam logic [CUBE_W-1:0] SOLVED = 72'hDB6_49B92D_49B92D_249;

  localparam int LCG_MUL   = 101;
  localparam int LCG_ADD   = 37;
  localparam int LCG_MOD   = 1000;
  localparam int SEED_WRAP = 999;

  typedef enum logic [1:0] {
    FACE_F       = 2'd0,
    FACE_U       = 2'd1,
    FACE_R       = 2'd2,
    FACE_ILLEGAL = 2'd3
  } face_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_APPLY    = 2'd1,
    ST_SCRAMBLE = 2'd2
  } state_e;

  // dir: 0 = CCW, 1 = CW
  typedef struct packed {
    logic [1:0] face;
    logic       dir;
  } move_t;

  function automatic logic [9:0] lcg_next(input logic [9:0] r);
    logic [16:0] t;
    t = 17'(r) * 17'(LCG_MUL) + 17'(LCG_ADD);
    return 10'(t % 17'(LCG_MOD));
  endfunction

  function automatic logic [1:0] rnd_face(input logic [9:0] r);
    return 2'(r % 10'd3);
  endfunction

endpackage

// File: rtl/cube_move_sched_if.sv
// Move/scramble/undo request bus and cube status outputs of cube_move_sched.
// Handshake: a move transfers on a rising edge where mv_valid && mv_ready; mv_ready never depends on mv_valid.
interface cube_move_sched_if;
  logic                      mv_valid;
  logic [1:0]                mv_face;
  logic                      mv_dir;
  logic                      mv_ready;
  logic                      scr_start;
  logic [7:0]                scr_len;
  logic                      undo;
  logic                      busy;
  logic [cube_pkg::CUBE_W-1:0] cube;
  logic                      solved;
  logic [15:0]               move_cnt;
  logic                      drop;
  cube_pkg::state_e          dbg_state;

  modport slave (
    input  mv_valid, mv_face, mv_dir, scr_start, scr_len, undo,
    output mv_ready, busy, cube, solved, move_cnt, drop, dbg_state
  );

  modport master (
    output mv_valid, mv_face, mv_dir, scr_start, scr_len, undo,
    input  mv_ready, busy, cube, solved, move_cnt, drop, dbg_state
  );
endinterface

// File: rtl/cube_turn.sv
// Combinational CCW quarter-turn of one face (F, U or R); face code 3 passes the state through.
module cube_turn
  import cube_pkg::*;
(
  input  logic [CUBE_W-1:0] i_state,
  input  logic [1:0]        i_face,
  output logic [CUBE_W-1:0] o_state
);

  logic [STICKER_W-1:0] w_s [N_STICKERS];
  logic [STICKER_W-1:0] w_n [N_STICKERS];

  always_comb begin
    for (int i = 0; i < N_STICKERS; i++) w_s[i] = i_state[i*STICKER_W +: STICKER_W];
    w_n = w_s;
    case (i_face)
      FACE_F: begin
        w_n[7]  = w_s[15]; w_n[15] = w_s[14]; w_n[14] = w_s[6];  w_n[6]  = w_s[7];
        w_n[3]  = w_s[16]; w_n[2]  = w_s[8];  w_n[16] = w_s[20]; w_n[8]  = w_s[21];
        w_n[20] = w_s[5];  w_n[21] = w_s[13]; w_n[5]  = w_s[3];  w_n[13] = w_s[2];
      end
      FACE_U: begin
        w_n[0]  = w_s[1];  w_n[1]  = w_s[3];  w_n[3]  = w_s[2];  w_n[2]  = w_s[0];
        w_n[11] = w_s[9];  w_n[10] = w_s[8];  w_n[9]  = w_s[7];  w_n[8]  = w_s[6];
        w_n[7]  = w_s[5];  w_n[6]  = w_s[4];  w_n[5]  = w_s[11]; w_n[4]  = w_s[10];
      end
      FACE_R: begin
        w_n[8]  = w_s[9];  w_n[9]  = w_s[17]; w_n[17] = w_s[16]; w_n[16] = w_s[8];
        w_n[3]  = w_s[10]; w_n[1]  = w_s[18]; w_n[10] = w_s[23]; w_n[18] = w_s[21];
        w_n[23] = w_s[15]; w_n[21] = w_s[7];  w_n[15] = w_s[3];  w_n[7]  = w_s[1];
      end
      default: ;
    endcase
    for (int i = 0; i < N_STICKERS; i++) o_state[i*STICKER_W +: STICKER_W] = w_n[i];
  end

endmodule

// File: rtl/cube_move_sched.sv
// Cube state owner: queues player moves, runs LCG scramble bursts, one CCW quarter-turn per cycle.
// Undo history is built only when CUBE_UNDO_EN is defined.
module cube_move_sched
  import cube_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int HDEPTH = 8
) (
  input logic              clk,
  input logic              rst,
  cube_move_sched_if.slave bus
);

  localparam int          AW     = $clog2(QDEPTH);
  localparam logic [AW:0] Q_FULL = QDEPTH[AW:0];

  state_e            r_state;
  logic [CUBE_W-1:0] r_cube;
  logic              r_solved;
  logic              r_drop;
  logic [15:0]       r_move_cnt;
  logic [9:0]        r_seed;
  logic [9:0]        r_rnd;
  logic [7:0]        r_cnt;
  logic [1:0]        r_rem;
  logic [1:0]        r_face;
  move_t             r_fifo [QDEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  logic              w_push;
  logic              w_illegal;
  logic              w_flush;
  logic              w_pop;
  logic [1:0]        w_turn_face;
  logic [CUBE_W-1:0] w_turned;
  move_t             w_head;

  assign bus.mv_ready  = (r_count != Q_FULL) && (r_state != ST_SCRAMBLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.cube      = r_cube;
  assign bus.solved    = r_solved;
  assign bus.move_cnt  = r_move_cnt;
  assign bus.drop      = r_drop;
  assign bus.dbg_state = r_state;

  assign w_push      = bus.mv_valid && bus.mv_ready && (bus.mv_face != FACE_ILLEGAL);
  assign w_illegal   = bus.mv_valid && bus.mv_ready && (bus.mv_face == FACE_ILLEGAL);
  assign w_flush     = (r_state == ST_IDLE) && bus.scr_start;
  assign w_pop       = (r_state == ST_IDLE) && !bus.scr_start && (r_count != '0);
  assign w_head      = r_fifo[r_rd_ptr];
  assign w_turn_face = (r_state == ST_SCRAMBLE) ? rnd_face(r_rnd) : r_face;

  cube_turn u_turn (
    .i_state (r_cube),
    .i_face  (w_turn_face),
    .o_state (w_turned)
  );

`ifdef CUBE_UNDO_EN
  localparam int            HW     = (HDEPTH > 1) ? $clog2(HDEPTH) : 1;
  localparam logic [HW:0]   H_FULL = HDEPTH[HW:0];
  localparam logic [HW-1:0] H_LAST = HW'(HDEPTH - 1);

  move_t         r_hist [HDEPTH];
  logic [HW-1:0] r_hist_top;  // next free slot; wraps so the oldest entry is overwritten
  logic [HW:0]   r_hist_cnt;
  logic [HW-1:0] w_hist_prev;
  logic          w_undo;

  assign w_hist_prev = (r_hist_top == '0) ? H_LAST : r_hist_top - 1'b1;
  assign w_undo      = (r_state == ST_IDLE) && !bus.scr_start && (r_count == '0)
                       && bus.undo && (r_hist_cnt != '0);
`endif

  // A push coinciding with a scramble flush is discarded along with the queue.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= '{face: bus.mv_face, dir: bus.mv_dir};
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cube     <= SOLVED;
      r_solved   <= 1'b1;
      r_drop     <= 1'b0;
      r_move_cnt <= '0;
      r_seed     <= 10'd1;
      r_rnd      <= '0;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_face     <= '0;
`ifdef CUBE_UNDO_EN
      r_hist_top <= '0;
      r_hist_cnt <= '0;
`endif
    end else begin
      r_seed   <= (r_seed == 10'(SEED_WRAP)) ? 10'd1 : r_seed + 10'd1;
      r_drop   <= w_illegal;
      r_solved <= (r_cube == SOLVED);
      case (r_state)
        ST_IDLE: begin
          if (w_flush) begin
            r_state <= ST_SCRAMBLE;
            r_cnt   <= bus.scr_len;
            r_rnd   <= r_seed;
          end else if (w_pop) begin
            r_state <= ST_APPLY;
            r_face  <= w_head.face;
            r_rem   <= w_head.dir ? 2'd3 : 2'd1;
            if (r_move_cnt != 16'hFFFF) r_move_cnt <= r_move_cnt + 16'd1;
`ifdef CUBE_UNDO_EN
            r_hist[r_hist_top] <= w_head;
            r_hist_top         <= (r_hist_top == H_LAST) ? '0 : r_hist_top + 1'b1;
            if (r_hist_cnt != H_FULL) r_hist_cnt <= r_hist_cnt + 1'b1;
          end else if (w_undo) begin
            r_state    <= ST_APPLY;
            r_face     <= r_hist[w_hist_prev].face;
            r_rem      <= r_hist[w_hist_prev].dir ? 2'd1 : 2'd3;
            r_hist_top <= w_hist_prev;
            r_hist_cnt <= r_hist_cnt - 1'b1;
            if (r_move_cnt != '0) r_move_cnt <= r_move_cnt - 16'd1;
`endif
          end
        end
        ST_APPLY: begin
          r_cube <= w_turned;
          r_rem  <= r_rem - 2'd1;
          if (r_rem == 2'd1) r_state <= ST_IDLE;
        end
        ST_SCRAMBLE: begin
          if (r_cnt != '0) begin
            r_cube <= w_turned;
            r_rnd  <= lcg_next(r_rnd);
            r_cnt  <= r_cnt - 8'd1;
          end
          if (r_cnt <= 8'd1) begin
            r_state    <= ST_IDLE;
            r_move_cnt <= '0;
`ifdef CUBE_UNDO_EN
            r_hist_top <= '0;
            r_hist_cnt <= '0;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cube_move_sched.sv
// Directed bench for cube_move_sched: moves, back-pressure, illegal drop, seeded scramble, undo.
module tb_cube_move_sched;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [71:0] exp_q[$];

  localparam logic [71:0] SOLVED_V = 72'hDB6_49B92D_49B92D_249;

  // Hand-derived sticker colours s0..s23 for the states the bench visits.
  int st_f[24]   = '{1,1,3,3,5,1,4,4,6,3,2,2,5,1,4,4,6,3,2,2,5,5,6,6};
  int st_ucw[24] = '{1,1,1,1,4,4,3,3,2,2,5,5,5,5,4,4,3,3,2,2,6,6,6,6};
  int st_rcw[24] = '{1,4,1,4,5,5,4,6,3,3,1,2,5,5,4,6,3,3,1,2,6,2,6,2};
  int st_a[24]   = '{1,3,1,3,2,2,5,1,4,4,6,3,5,1,4,4,6,3,2,2,5,5,6,6};
  int st_b[24]   = '{1,2,1,6,2,2,5,3,4,3,6,3,5,1,4,3,4,6,5,2,5,1,6,4};
  int st_c[24]   = '{2,6,1,1,6,3,2,2,5,3,4,3,5,1,4,3,4,6,5,2,5,1,6,4};

  cube_move_sched_if bus ();

  cube_move_sched #(.QDEPTH(4), .HDEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] pack(input int s[24]);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 24; i++) v[i*3 +: 3] = 3'(s[i]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Returns 1 time unit after the accepting edge.
  task automatic push(input logic [1:0] face, input logic dir);
    int n;
    @(negedge clk);
    bus.mv_valid = 1'b1;
    bus.mv_face  = face;
    bus.mv_dir   = dir;
    n = 0;
    while (bus.mv_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_wait", 72'(n < 50), 72'd1);
    @(posedge clk);
    #1 bus.mv_valid = 1'b0;
  endtask

  task automatic scramble(input logic [7:0] len);
    @(negedge clk);
    bus.scr_start = 1'b1;
    bus.scr_len   = len;
    @(posedge clk);
    #1 bus.scr_start = 1'b0;
  endtask

  task automatic pulse_undo();
    @(negedge clk);
    bus.undo = 1'b1;
    @(posedge clk);
    #1 bus.undo = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.mv_valid = 1'b0; bus.mv_face = 2'd0; bus.mv_dir = 1'b0;
    bus.scr_start = 1'b0; bus.scr_len = 8'd0; bus.undo = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    tick(5);
    chk("rst_cube",     bus.cube,            SOLVED_V);
    chk("rst_solved",   72'(bus.solved),     72'd1);
    chk("rst_ready",    72'(bus.mv_ready),   72'd1);
    chk("rst_busy",     72'(bus.busy),       72'd0);
    chk("rst_move_cnt", 72'(bus.move_cnt),   72'd0);
    chk("rst_drop",     72'(bus.drop),       72'd0);

    // single F CCW: visible after E+2, solved lags one cycle
    push(2'd0, 1'b0);
    tick(1);
    chk("f_busy",     72'(bus.busy),     72'd1);
    chk("f_pending",  bus.cube,          SOLVED_V);
    tick(1);
    chk("f_cube",     bus.cube,          pack(st_f));
    chk("f_move_cnt", 72'(bus.move_cnt), 72'd1);
    chk("f_idle",     72'(bus.busy),     72'd0);
    tick(1);
    chk("f_solved",   72'(bus.solved),   72'd0);

    // three more F CCW back-to-back return to SOLVED
    push(2'd0, 1'b0);
    push(2'd0, 1'b0);
    push(2'd0, 1'b0);
    tick(10);
    chk("f4_cube",     bus.cube,          SOLVED_V);
    chk("f4_move_cnt", 72'(bus.move_cnt), 72'd4);
    chk("f4_solved",   72'(bus.solved),   72'd1);

    // U CW lands after E+4, U CCW undoes it
    push(2'd1, 1'b1);
    tick(3);
    chk("ucw_busy",  72'(bus.busy), 72'd1);
    tick(1);
    chk("ucw_cube",  bus.cube,      pack(st_ucw));
    chk("ucw_idle",  72'(bus.busy), 72'd0);
    push(2'd1, 1'b0);
    tick(2);
    chk("uccw_cube",     bus.cube,          SOLVED_V);
    chk("uccw_move_cnt", 72'(bus.move_cnt), 72'd6);

    // back-pressure: four writes fill the queue while R CW runs
    push(2'd2, 1'b1);
    push(2'd2, 1'b0);
    push(2'd1, 1'b0);
    push(2'd1, 1'b0);
    chk("bp_ready_3", 72'(bus.mv_ready), 72'd1);
    push(2'd1, 1'b0);
    chk("bp_ready_full", 72'(bus.mv_ready), 72'd0);
    push(2'd1, 1'b0);
    tick(20);
    chk("bp_cube",     bus.cube,          SOLVED_V);
    chk("bp_move_cnt", 72'(bus.move_cnt), 72'd12);
    chk("bp_busy",     72'(bus.busy),     72'd0);

    // illegal face: drop pulse only
    push(2'd3, 1'b0);
    chk("drop_hi", 72'(bus.drop), 72'd1);
    tick(1);
    chk("drop_lo", 72'(bus.drop), 72'd0);
    tick(5);
    chk("drop_cube",     bus.cube,          SOLVED_V);
    chk("drop_move_cnt", 72'(bus.move_cnt), 72'd12);
    chk("drop_busy",     72'(bus.busy),     72'd0);

    // scramble from seed 10 (edge 10 after reset): U, R, U; queued move flushed
    do_reset();
    push(2'd0, 1'b0);
    tick(7);
    chk("pre_scr_cube",     bus.cube,          pack(st_f));
    chk("pre_scr_move_cnt", 72'(bus.move_cnt), 72'd1);
    push(2'd2, 1'b1);
    scramble(8'd3);
    chk("scr_busy",  72'(bus.busy),     72'd1);
    chk("scr_ready", 72'(bus.mv_ready), 72'd0);
    chk("scr_entry", bus.cube,          pack(st_f));
    exp_q.push_back(pack(st_a));
    exp_q.push_back(pack(st_b));
    exp_q.push_back(pack(st_c));
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("scr_turn", bus.cube, exp_q.pop_front());
    end
    chk("scr_done_busy",     72'(bus.busy),     72'd0);
    chk("scr_done_move_cnt", 72'(bus.move_cnt), 72'd0);
    tick(6);
    chk("scr_flushed", bus.cube, pack(st_c));
    chk("scr_after_busy", 72'(bus.busy), 72'd0);

    // zero-length scramble leaves the cube alone
    scramble(8'd0);
    chk("scr0_busy", 72'(bus.busy), 72'd1);
    tick(1);
    chk("scr0_idle", 72'(bus.busy), 72'd0);
    tick(2);
    chk("scr0_cube", bus.cube,      pack(st_c));

    // R CW, then undo behaviour
    do_reset();
    push(2'd2, 1'b1);
    tick(4);
    chk("rcw_cube",     bus.cube,          pack(st_rcw));
    chk("rcw_move_cnt", 72'(bus.move_cnt), 72'd1);
    chk("rcw_busy",     72'(bus.busy),     72'd0);
`ifdef CUBE_UNDO_EN
    pulse_undo();
    chk("undo_busy",     72'(bus.busy),     72'd1);
    chk("undo_move_cnt", 72'(bus.move_cnt), 72'd0);
    tick(1);
    chk("undo_cube",     bus.cube,          SOLVED_V);
    chk("undo_idle",     72'(bus.busy),     72'd0);
    pulse_undo();
    chk("undo_empty_busy", 72'(bus.busy),   72'd0);
    tick(2);
    chk("undo_empty_cube", bus.cube,        SOLVED_V);
    chk("undo_empty_cnt",  72'(bus.move_cnt), 72'd0);
`else
    pulse_undo();
    chk("noundo_busy", 72'(bus.busy),     72'd0);
    tick(2);
    chk("noundo_cube", bus.cube,          pack(st_rcw));
    chk("noundo_cnt",  72'(bus.move_cnt), 72'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cube_move_sched.md
Name: cube_move_sched

Overview:
- Owns the 72-bit 2x2 cube state register and sequences every quarter-turn applied to it.
- Arbitrates between three sources: queued player moves, an LCG-driven scramble burst, and (optionally) undo.
- Sits between the keypad/debounce front end and the display renderer.
- Applies exactly one CCW quarter-turn per cycle. A CW turn is executed as three CCW turns.

Parameters:
- QDEPTH, 4, player move FIFO depth (power of 2, >=2).
- HDEPTH, 8, undo history depth (used only with CUBE_UNDO_EN).

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- mv_valid  in  1  player move offered.
- mv_face  in  2  face: 0=F, 1=U, 2=R, 3=illegal.
- mv_dir  in  1  direction: 0=CCW, 1=CW.
- mv_ready  out  1  FIFO can accept.
- scr_start  in  1  scramble request.
- scr_len  in  8  scramble quarter-turn count.
- undo  in  1  undo pulse (ignored without CUBE_UNDO_EN).
- busy  out  1  FSM not IDLE.
- cube  out  72  sticker state. Sticker si = cube[3i+2:3i], 3-bit colour.
- solved  out  1  cube equals SOLVED.
- move_cnt  out  16  player quarter-move count.
- drop  out  1  1-cycle pulse when an illegal face is offered.

Behaviour:
- Reset values: cube=SOLVED=72'hDB6_49B92D_49B92D_249; solved=1; move_cnt=0; busy=0; drop=0; FIFO empty; mv_ready=1; seed_cnt=1; FSM=IDLE.
- seed_cnt: increments every non-reset edge, wraps 999->1.
- CCW turn permutations, all assignments simultaneous. These live in cube_turn.
  - F: s7<=s15, s15<=s14, s14<=s6, s6<=s7; {s3,s2}<={s16,s8}; {s16,s8}<={s20,s21}; {s20,s21}<={s5,s13}; {s5,s13}<={s3,s2}.
  - U: s0<=s1, s1<=s3, s3<=s2, s2<=s0; {s11,s10}<={s9,s8}; {s9,s8}<={s7,s6}; {s7,s6}<={s5,s4}; {s5,s4}<={s11,s10}.
  - R: s8<=s9, s9<=s17, s17<=s16, s16<=s8; {s3,s1}<={s10,s18}; {s10,s18}<={s23,s21}; {s23,s21}<={s15,s7}; {s15,s7}<={s3,s1}.
- FIFO handshake:
  - A move is written on an edge where mv_valid&&mv_ready and mv_face!=3.
  - mv_face==3: not written, drop pulses next cycle.
  - mv_ready = !full && state!=SCRAMBLE.
  - A simultaneous push and pop while full is not allowed, because ready is already 0.
- FSM states: IDLE, APPLY, SCRAMBLE.
- IDLE, in priority order:
  - scr_start: accepted. Go to SCRAMBLE, cnt<=scr_len, rnd<=seed_cnt (pre-edge value), FIFO flushed.
  - Else, if the FIFO is non-empty: pop. Go to APPLY with rem = 1 (CCW) or 3 (CW). move_cnt += 1, saturating at 16'hFFFF.
- APPLY: apply one CCW turn of the latched face per cycle; rem-=1. When rem==1, return to IDLE.
- SCRAMBLE:
  - If cnt==0: return to IDLE with no change.
  - Else: apply CCW of face rnd%3; rnd<=(rnd*101+37)%1000; cnt-=1. Return to IDLE after the last turn.
  - On exit: move_cnt<=0 and history cleared.
- scr_start outside IDLE: ignored, with no latching.
- Latency:
  - Move handshaken at edge E into an empty FIFO while IDLE: a CCW result is visible after edge E+2; a CW result after E+4.
  - One IDLE cycle separates consecutive queued moves.
- solved: registered compare, lags cube by one cycle.
- rst asserted mid-APPLY or mid-SCRAMBLE: all state returns to its reset values on that edge. Partial turns are not retained.

Optional Feature:
- Macro: CUBE_UNDO_EN.
- When defined:
  - Each popped player move is pushed onto an HDEPTH-entry history stack. When full, the oldest entry is overwritten.
  - undo in IDLE with no scr_start and an empty FIFO pops the stack. The inverse move is applied via APPLY (CW<->CCW, i.e. rem 3/1). move_cnt -= 1, floor 0.
  - undo with an empty stack, or outside IDLE: ignored.
- When undefined: no stack is built and undo has no effect.

Decomposition:
- Package cube_pkg:
  - SOLVED constant.
  - Face codes F/U/R/ILLEGAL.
  - Sticker width 3.
  - LCG constants 101, 37, 1000; seed wrap 999.
  - FSM state encoding.
- Sub-module cube_turn: purely combinational. Inputs: 72-bit state and 2-bit face. Output: the CCW-turned state.
- The FIFO stays inline.

Test Plan:
- Reset, then idle 5 cycles -> cube=SOLVED, solved=1, mv_ready=1, busy=0.
- Push F CCW -> after E+2: s2=s3=3, s8=s16=6, s20=s21=5, s5=s13=1; move_cnt=1; solved=0.
- Push four F CCW back-to-back -> cube returns to SOLVED. Then push U CW, then U CCW -> SOLVED again; move_cnt=6.
- Hold mv_valid with QDEPTH+2 moves while one CW executes -> mv_ready drops after 4 writes; no move lost or duplicated; face=3 pulses drop and is not queued.
- scr_start with scr_len=3 when seed_cnt=10 (9 edges after rst release) -> U, R, U CCW applied on consecutive cycles; move_cnt=0; queued moves flushed. scr_len=0 -> cube unchanged.
- CUBE_UNDO_EN: R CW then undo -> SOLVED, move_cnt=0. Undo on an empty stack -> no change.
